// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code helpers and defaults for gray_counter and gray_step_chk
package gray_pkg;

    localparam int GRAY_SIZE_DEFAULT = 4;
    // Widest count the helpers handle; callers zero-extend into it and truncate the result back
    localparam int GRAY_MAX_W = 64;
    localparam int GRAY_PC_W = $clog2(GRAY_MAX_W + 1);

    // Zero-extended input keeps the top Gray bit equal to the top binary bit at any narrower width
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GRAY_PC_W-1:0] popcount(input logic [GRAY_MAX_W-1:0] val);
        logic [GRAY_PC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < GRAY_MAX_W; i++) cnt = cnt + GRAY_PC_W'(val[i]);
        return cnt;
    endfunction

endpackage

// File: rtl/gray_step_chk.sv
// gray_step_chk: flags any count step whose Gray output changed by other than exactly one bit
module gray_step_chk
    import gray_pkg::*;
#(
    parameter int SIZE = GRAY_SIZE_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] gray,
    input  logic            step,
    output logic            err
);

    logic [SIZE-1:0] prev;
    logic            stepped;

    // Remember the code before each update and whether that update was a count step; errors stick until reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev    <= '0;
            stepped <= 1'b0;
            err     <= 1'b0;
        end else begin
            prev    <= gray;
            stepped <= step;
            if (stepped && popcount(GRAY_MAX_W'(gray ^ prev)) != GRAY_PC_W'(1)) err <= 1'b1;
        end
    end

endmodule

// File: rtl/gray_counter.sv
// gray_counter: binary up/down counter with registered Gray, binary, wrap and valid outputs; GRAY_CNT_CHK_EN adds the Err_o step checker
module gray_counter
    import gray_pkg::*;
#(
    parameter int SIZE = GRAY_SIZE_DEFAULT
) (
    input  logic            Clk_i,
    input  logic            Rst_n_i,
    input  logic            En_i,
    input  logic            Dir_i,
    input  logic            Load_i,
    input  logic [SIZE-1:0] LoadBin_i,
    output logic [SIZE-1:0] Gray_o,
    output logic [SIZE-1:0] Bin_o,
    output logic            Wrap_o,
    output logic            Valid_o
`ifdef GRAY_CNT_CHK_EN
    ,
    output logic            Err_o
`endif
);

    logic [SIZE-1:0] step_bin;
    logic [SIZE-1:0] next_bin;
    logic [SIZE-1:0] gray_next;
    logic            cnt_step;
    logic            upd;
    logic            wrap_next;

    // Next count and its Gray code are computed here so Gray_o itself is a bare flop
    always_comb begin
        step_bin  = Dir_i ? Bin_o + SIZE'(1) : Bin_o - SIZE'(1);
        cnt_step  = En_i && !Load_i;
        upd       = Load_i || En_i;
        next_bin  = Load_i ? LoadBin_i : step_bin;
        wrap_next = cnt_step && (Dir_i ? &Bin_o : ~|Bin_o);
        gray_next = SIZE'(bin2gray(GRAY_MAX_W'(next_bin)));
    end

    // Binary and Gray registers update together; pulses clear on any non-updating cycle
    always_ff @(posedge Clk_i) begin
        if (!Rst_n_i) begin
            Bin_o   <= '0;
            Gray_o  <= '0;
            Wrap_o  <= 1'b0;
            Valid_o <= 1'b0;
        end else if (upd) begin
            Bin_o   <= next_bin;
            Gray_o  <= gray_next;
            Wrap_o  <= wrap_next;
            Valid_o <= 1'b1;
        end else begin
            Wrap_o  <= 1'b0;
            Valid_o <= 1'b0;
        end
    end

`ifdef GRAY_CNT_CHK_EN
    gray_step_chk #(.SIZE(SIZE)) u_chk (
        .clk   (Clk_i),
        .rst_n (Rst_n_i),
        .gray  (Gray_o),
        .step  (cnt_step),
        .err   (Err_o)
    );
`endif

endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: directed checks of gray_counter at SIZE=4 (checker tests only with GRAY_CNT_CHK_EN)
module tb_gray_counter;

    logic       clk = 1'b0;
    logic       rst_n, en, dir, load;
    logic [3:0] load_bin, gray, bin;
    logic       wrap, valid;
    int         checks = 0;
    int         failures = 0;
`ifdef GRAY_CNT_CHK_EN
    logic       err;
`endif

    gray_counter #(.SIZE(4)) dut (
        .Clk_i     (clk),
        .Rst_n_i   (rst_n),
        .En_i      (en),
        .Dir_i     (dir),
        .Load_i    (load),
        .LoadBin_i (load_bin),
        .Gray_o    (gray),
        .Bin_o     (bin),
        .Wrap_o    (wrap),
        .Valid_o   (valid)
`ifdef GRAY_CNT_CHK_EN
        ,
        .Err_o     (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; load = 1'b1; load_bin = 4'd9; dir = 1'b1;
        tick(); tick();
        checks++; if (bin !== 4'd0) begin failures++; $display("FAIL reset_bin got=%0d exp=0", bin); end
        checks++; if (gray !== 4'b0000) begin failures++; $display("FAIL reset_gray got=%b exp=0000", gray); end
        checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
`ifdef GRAY_CNT_CHK_EN
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
`endif
    endtask

    task automatic test_up_count();
        logic [3:0] exp_gray [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                                      4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        rst_n = 1'b1; load = 1'b0; en = 1'b1; dir = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++; if (gray !== exp_gray[i]) begin failures++; $display("FAIL up_gray step=%0d got=%b exp=%b", i + 1, gray, exp_gray[i]); end
            checks++; if (bin !== 4'((i + 1) % 16)) begin failures++; $display("FAIL up_bin step=%0d got=%0d exp=%0d", i + 1, bin, (i + 1) % 16); end
            checks++; if (valid !== 1'b1) begin failures++; $display("FAIL up_valid step=%0d got=%b exp=1", i + 1, valid); end
            checks++; if (wrap !== (i == 15)) begin failures++; $display("FAIL up_wrap step=%0d got=%b exp=%b", i + 1, wrap, i == 15); end
        end
    endtask

    task automatic test_down_wrap();
        en = 1'b1; dir = 1'b0;
        tick();
        checks++; if (bin !== 4'd15) begin failures++; $display("FAIL down_bin got=%0d exp=15", bin); end
        checks++; if (gray !== 4'b1000) begin failures++; $display("FAIL down_gray got=%b exp=1000", gray); end
        checks++; if (wrap !== 1'b1) begin failures++; $display("FAIL down_wrap got=%b exp=1", wrap); end
        tick();
        checks++; if (bin !== 4'd14 || gray !== 4'b1001) begin failures++; $display("FAIL down_14 got=%0d/%b exp=14/1001", bin, gray); end
        checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL down_nowrap got=%b exp=0", wrap); end
        en = 1'b0;
        tick();
        checks++; if (bin !== 4'd14 || gray !== 4'b1001) begin failures++; $display("FAIL hold_val got=%0d/%b exp=14/1001", bin, gray); end
        checks++; if (valid !== 1'b0 || wrap !== 1'b0) begin failures++; $display("FAIL hold_pulses got=%b%b exp=00", valid, wrap); end
    endtask

    task automatic test_load_vs_enable();
        load = 1'b1; en = 1'b1; dir = 1'b0; load_bin = 4'd9;
        tick();
        checks++; if (bin !== 4'd9 || gray !== 4'b1101) begin failures++; $display("FAIL load_val got=%0d/%b exp=9/1101", bin, gray); end
        checks++; if (valid !== 1'b1 || wrap !== 1'b0) begin failures++; $display("FAIL load_pulses got=%b%b exp=10", valid, wrap); end
        load = 1'b0; dir = 1'b1;
        tick();
        checks++; if (bin !== 4'd10 || gray !== 4'b1111) begin failures++; $display("FAIL load_next got=%0d/%b exp=10/1111", bin, gray); end
        load = 1'b1; en = 1'b0; load_bin = 4'd10;
        tick();
        checks++; if (bin !== 4'd10 || valid !== 1'b1) begin failures++; $display("FAIL load_same got=%0d/%b exp=10/1", bin, valid); end
        load_bin = 4'd15;
        tick();
        load_bin = 4'd3; en = 1'b1; dir = 1'b1;
        tick();
        checks++; if (bin !== 4'd3 || gray !== 4'b0010 || wrap !== 1'b0) begin failures++; $display("FAIL load_at_max got=%0d/%b/%b exp=3/0010/0", bin, gray, wrap); end
    endtask

    task automatic test_dir_alternate();
        logic       dirs [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0] exp_b [4] = '{4'd4, 4'd3, 4'd2, 4'd3};
        logic [3:0] exp_g [4] = '{4'b0110, 4'b0010, 4'b0011, 4'b0010};
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dir = dirs[i];
            tick();
            checks++; if (bin !== exp_b[i] || gray !== exp_g[i]) begin failures++; $display("FAIL dir_alt step=%0d got=%0d/%b exp=%0d/%b", i, bin, gray, exp_b[i], exp_g[i]); end
        end
    endtask

    task automatic test_reset_mid_count();
        load = 1'b1; load_bin = 4'd4; en = 1'b1; dir = 1'b1;
        tick();
        load = 1'b0;
        tick();
        checks++; if (bin !== 4'd5) begin failures++; $display("FAIL mid_pre got=%0d exp=5", bin); end
        rst_n = 1'b0;
        tick();
        checks++; if (bin !== 4'd0 || gray !== 4'b0000 || valid !== 1'b0 || wrap !== 1'b0) begin failures++; $display("FAIL mid_reset got=%0d/%b/%b%b exp=0/0000/00", bin, gray, valid, wrap); end
        rst_n = 1'b1;
        tick();
        checks++; if (bin !== 4'd1 || gray !== 4'b0001 || valid !== 1'b1) begin failures++; $display("FAIL mid_resume got=%0d/%b/%b exp=1/0001/1", bin, gray, valid); end
    endtask

`ifdef GRAY_CNT_CHK_EN
    task automatic test_chk();
        logic [3:0] model;
        logic [3:0] bad;
        load = 1'b1; en = 1'b0; load_bin = 4'd0;
        tick();
        load_bin = 4'd15;
        tick();
        load = 1'b0; en = 1'b1; model = 4'd15;
        for (int i = 0; i < 32; i++) begin
            dir = 1'($urandom_range(0, 1));
            model = dir ? model + 4'd1 : model - 4'd1;
            tick();
        end
        checks++; if (bin !== model) begin failures++; $display("FAIL chk_rand_bin got=%0d exp=%0d", bin, model); end
        tick();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL chk_clean got=%b exp=0", err); end
        bad = gray ^ 4'b0110;
        force dut.u_chk.prev = bad;
        en = 1'b0;
        tick();
        release dut.u_chk.prev;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL chk_detect got=%b exp=1", err); end
        en = 1'b1;
        tick(); tick(); tick();
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL chk_sticky got=%b exp=1", err); end
        rst_n = 1'b0;
        tick();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL chk_reset got=%b exp=0", err); end
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_up_count();
        test_down_wrap();
        test_load_vs_enable();
        test_dir_alternate();
        test_reset_mid_count();
`ifdef GRAY_CNT_CHK_EN
        test_chk();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
